// File: rtl/oscope_pkg.sv
`default_nettype none
// ============================================================================
// Module  : oscope_pkg
// Brief   : Shared types and constants for the oscilloscope decimator.
// Revision: 1.0 - initial release
// ============================================================================
package oscope_pkg;

  localparam int OSC_SH_MAX = 8;
  localparam int OSC_DW     = 8;

  typedef enum logic [1:0] {
    DEC_SAMPLE = 2'd0,
    DEC_PEAK   = 2'd1,
    DEC_AVG    = 2'd2
  } osc_dec_mode_e;

  typedef logic signed [OSC_DW-1:0] sample_t;

  function automatic logic [3:0] osc_clamp_sh(input logic [3:0] sh, input logic [3:0] sh_max);
    return (sh > sh_max) ? sh_max : sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/osc_dec_peak_tracker.sv
`default_nettype none
// ============================================================================
// Module  : osc_dec_peak_tracker
// Brief   : Running min/max over a window; *_nxt include the current sample.
// Revision: 1.0 - initial release
// ============================================================================
module osc_dec_peak_tracker #(
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 init,
  input  logic                 update,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] min_nxt,
  output logic signed [DW-1:0] max_nxt
);

  logic signed [DW-1:0] r_min;
  logic signed [DW-1:0] r_max;

  assign min_nxt = init ? din : ((din < r_min) ? din : r_min);
  assign max_nxt = init ? din : ((din > r_max) ? din : r_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '0;
      r_max <= '0;
    end else if (clear) begin
      r_min <= '0;
      r_max <= '0;
    end else if (init || update) begin
      r_min <= min_nxt;
      r_max <= max_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/oscope_decimator.sv
`default_nettype none
// ============================================================================
// Module  : oscope_decimator
// Brief   : ADC stream decimator with SAMPLE / PEAK / AVG acquisition modes.
//           AVG mode is built only when OSC_DEC_AVG_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module oscope_decimator
  import oscope_pkg::*;
#(
  parameter int DW     = 8,
  parameter int DIV_W  = 16,
  parameter int SH_MAX = OSC_SH_MAX
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [DW-1:0]    din,
  input  logic                    din_valid,
  input  logic [1:0]              mode,
  input  logic [DIV_W-1:0]        div,
  input  logic [3:0]              avg_sh,
  input  logic                    restart,
  output logic signed [DW-1:0]    dout,
  output logic                    dout_en
);

  localparam int CW = (DIV_W > SH_MAX) ? DIV_W : SH_MAX;

  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_last;
  osc_dec_mode_e        r_mode;
  logic                 r_phase;
  logic signed [DW-1:0] r_dout;
  logic                 r_dout_en;

  logic                 w_first;
  logic [CW-1:0]        w_cnt;
  logic [CW-1:0]        w_div_last;
  logic [CW-1:0]        w_last_live;
  logic [CW-1:0]        w_last;
  osc_dec_mode_e        w_mode_live;
  osc_dec_mode_e        w_mode;
  logic                 w_end;
  logic                 w_phase;
  logic signed [DW-1:0] w_min;
  logic signed [DW-1:0] w_max;
  logic signed [DW-1:0] w_out;

  // The first sample of a window sees the live configuration, later ones the latched copy.
  assign w_first    = restart || (r_cnt == '0);
  assign w_cnt      = restart ? '0 : r_cnt;
  assign w_phase    = restart ? 1'b0 : r_phase;
  assign w_div_last = (div == '0) ? '0 : CW'(div - DIV_W'(1));
  assign w_mode     = w_first ? w_mode_live : r_mode;
  assign w_last     = w_first ? w_last_live : r_last;
  assign w_end      = (w_cnt == w_last);

  always_comb begin
    case (mode)
      2'd1:    w_mode_live = DEC_PEAK;
`ifdef OSC_DEC_AVG_EN
      2'd2:    w_mode_live = DEC_AVG;
`endif
      default: w_mode_live = DEC_SAMPLE;
    endcase
  end

`ifdef OSC_DEC_AVG_EN
  localparam int         AW        = DW + SH_MAX;
  localparam logic [3:0] C_SH_MAX  = 4'(SH_MAX);

  logic [3:0]           r_sh;
  logic signed [AW-1:0] r_acc;
  logic [3:0]           w_sh_live;
  logic [3:0]           w_sh;
  logic [CW-1:0]        w_avg_last;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_avg;

  assign w_sh_live   = osc_clamp_sh(avg_sh, C_SH_MAX);
  assign w_sh        = w_first ? w_sh_live : r_sh;
  assign w_avg_last  = (CW'(1) << w_sh_live) - CW'(1);
  assign w_last_live = (w_mode_live == DEC_AVG) ? w_avg_last : w_div_last;
  assign w_sum       = (w_first ? '0 : r_acc) + AW'(din);
  assign w_avg       = w_sum >>> w_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_sh  <= '0;
    end else if (din_valid) begin
      r_acc <= w_end ? '0 : w_sum;
      if (w_first) r_sh <= w_sh_live;
    end else if (restart) begin
      r_acc <= '0;
      r_sh  <= w_sh_live;
    end
  end
`else
  logic w_unused_avg_sh;
  assign w_unused_avg_sh = ^avg_sh;
  assign w_last_live     = w_div_last;
`endif

  osc_dec_peak_tracker #(.DW(DW)) u_peak (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (restart && !din_valid),
    .init    (din_valid && w_first),
    .update  (din_valid && !w_first),
    .din     (din),
    .min_nxt (w_min),
    .max_nxt (w_max)
  );

  always_comb begin
    case (w_mode)
      DEC_PEAK: w_out = w_phase ? w_min : w_max;
`ifdef OSC_DEC_AVG_EN
      DEC_AVG:  w_out = w_avg[DW-1:0];
`endif
      default:  w_out = din;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_last    <= '0;
      r_mode    <= DEC_SAMPLE;
      r_phase   <= 1'b0;
      r_dout    <= '0;
      r_dout_en <= 1'b0;
    end else begin
      r_dout_en <= din_valid && w_end;
      if (din_valid) begin
        r_cnt   <= w_end ? '0 : w_cnt + CW'(1);
        r_phase <= (w_end && (w_mode == DEC_PEAK)) ? ~w_phase : w_phase;
        if (w_first) begin
          r_mode <= w_mode_live;
          r_last <= w_last_live;
        end
        if (w_end) r_dout <= w_out;
      end else if (restart) begin
        r_cnt   <= '0;
        r_phase <= 1'b0;
        r_mode  <= w_mode_live;
        r_last  <= w_last_live;
      end
    end
  end

  assign dout    = r_dout;
  assign dout_en = r_dout_en;

endmodule
`default_nettype wire

// File: tb/tb_oscope_decimator.sv
`default_nettype none
// ============================================================================
// Module  : tb_oscope_decimator
// Brief   : Directed self-checking bench for oscope_decimator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_oscope_decimator;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [7:0] din = '0;
  logic              din_valid = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [15:0]       div = 16'd4;
  logic [3:0]        avg_sh = 4'd0;
  logic              restart = 1'b0;
  logic signed [7:0] dout;
  logic              dout_en;

  int n_checks = 0;
  int n_errors = 0;

`ifdef OSC_DEC_AVG_EN
  localparam int EXP_AVG0  = 2;
  localparam int EXP_AVG1  = -3;
  localparam int EXP_CLAMP = -1;
`else
  localparam int EXP_AVG0  = 5;
  localparam int EXP_AVG1  = -5;
  localparam int EXP_CLAMP = 127;
`endif

  oscope_decimator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .mode      (mode),
    .div       (div),
    .avg_sh    (avg_sh),
    .restart   (restart),
    .dout      (dout),
    .dout_en   (dout_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Present one input cycle; returns with outputs settled after that edge.
  task automatic push(input logic v, input int d, input logic rs);
    @(negedge clk);
    din_valid = v;
    din       = d[7:0];
    restart   = rs;
    @(posedge clk);
    #1;
  endtask

  int peak_in [16];
  int avg_in  [8];
  int n_en;

  initial begin
    #2;
    check("reset_dout", int'(dout), 0);
    check("reset_en", int'(dout_en), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // SAMPLE, div=4, ramp
    mode = 2'd0; div = 16'd4;
    for (int i = 0; i < 16; i++) begin
      push(1'b1, i, 1'b0);
      check("sample_en", int'(dout_en), (i % 4 == 3) ? 1 : 0);
      if (i % 4 == 3) check("sample_dout", int'(dout), i);
    end

    // div=0 behaves as 1
    push(1'b0, 0, 1'b1);
    div = 16'd0;
    for (int i = 20; i < 25; i++) begin
      push(1'b1, i, 1'b0);
      check("div0_en", int'(dout_en), 1);
      check("div0_dout", int'(dout), i);
    end
    push(1'b0, 99, 1'b0);
    check("div0_gap_en", int'(dout_en), 0);
    check("div0_hold", int'(dout), 24);

    // div=1 in PEAK and AVG(sh=0): every sample passes through
    div = 16'd1; mode = 2'd1;
    push(1'b1, -7, 1'b0); check("peak1_dout", int'(dout), -7);
    push(1'b1, 9, 1'b0);  check("peak1_dout", int'(dout), 9);
    push(1'b1, -2, 1'b0); check("peak1_dout", int'(dout), -2);
    check("peak1_en", int'(dout_en), 1);
    mode = 2'd2; avg_sh = 4'd0;
    push(1'b1, -33, 1'b0); check("avg1_dout", int'(dout), -33);
    check("avg1_en", int'(dout_en), 1);

    // PEAK, div=4, glitches at 1 and 6
    push(1'b0, 0, 1'b1);
    mode = 2'd1; div = 16'd4;
    for (int i = 0; i < 16; i++) peak_in[i] = -5;
    peak_in[1] = 100; peak_in[6] = -90;
    for (int i = 0; i < 16; i++) begin
      push(1'b1, peak_in[i], 1'b0);
      check("peak_en", int'(dout_en), (i % 4 == 3) ? 1 : 0);
      case (i)
        3:  check("peak_w0_max", int'(dout), 100);
        4:  check("peak_hold", int'(dout), 100);
        7:  check("peak_w1_min", int'(dout), -90);
        11: check("peak_w2_max", int'(dout), -5);
        15: check("peak_w3_min", int'(dout), -5);
        default: ;
      endcase
    end

    // AVG, avg_sh=2 (div kept at 4 so the non-AVG build has the same window)
    push(1'b0, 0, 1'b1);
    mode = 2'd2; avg_sh = 4'd2; div = 16'd4;
    avg_in = '{1, 2, 3, 5, -1, -2, -3, -5};
    for (int i = 0; i < 8; i++) begin
      push(1'b1, avg_in[i], 1'b0);
      check("avg_en", int'(dout_en), (i % 4 == 3) ? 1 : 0);
      if (i == 3) check("avg_pos", int'(dout), EXP_AVG0);
      if (i == 7) check("avg_neg", int'(dout), EXP_AVG1);
    end

    // avg_sh above the maximum clamps to a 256-sample window
    push(1'b0, 0, 1'b1);
    avg_sh = 4'd15; div = 16'd256;
    n_en = 0;
    for (int i = 0; i < 256; i++) begin
      push(1'b1, (i < 128) ? -128 : 127, 1'b0);
      if (dout_en) n_en++;
    end
    check("clamp_strobes", n_en, 1);
    check("clamp_last_en", int'(dout_en), 1);
    check("clamp_dout", int'(dout), EXP_CLAMP);

    // restart together with a valid sample starts a new window at that sample
    push(1'b0, 0, 1'b1);
    mode = 2'd0; div = 16'd4;
    push(1'b1, 50, 1'b0); check("rst_w_en", int'(dout_en), 0);
    push(1'b1, 51, 1'b0); check("rst_w_en", int'(dout_en), 0);
    push(1'b1, 52, 1'b1); check("rst_w_en", int'(dout_en), 0);
    push(1'b1, 53, 1'b0); check("rst_w_en", int'(dout_en), 0);
    push(1'b1, 54, 1'b0); check("rst_w_en", int'(dout_en), 0);
    push(1'b1, 55, 1'b0);
    check("restart_en", int'(dout_en), 1);
    check("restart_dout", int'(dout), 55);

    // async reset mid-window with PEAK phase=1
    push(1'b0, 0, 1'b1);
    mode = 2'd1; div = 16'd2;
    push(1'b1, 10, 1'b0);
    push(1'b1, 20, 1'b0);
    check("pre_rst_max", int'(dout), 20);
    push(1'b1, 30, 1'b0);
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout", int'(dout), 0);
    check("async_rst_en", int'(dout_en), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b1, 7, 1'b0); check("post_rst_en", int'(dout_en), 0);
    push(1'b1, 3, 1'b0);
    check("post_rst_en", int'(dout_en), 1);
    check("post_rst_max", int'(dout), 7);

    push(1'b0, 0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
